mux_rr: RTL
===========

# mux_rr

Parametrised N-channel round-robin multiplexer with valid/ready handshakes on every input and a registered output stage. It merges CHANNELS independent WIDTH-bit streams onto one output stream and grants contending channels fairly. It replaces fixed 2:1 select muxes on datapaths where several producers share one consumer and neither side may drop data.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2, need not be a power of two)
- SEL_W, $clog2(CHANNELS), width of channel index (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel beat available
- in_ready  output  CHANNELS  per-channel beat accepted this cycle (combinational)
- in_last  input  CHANNELS  last beat of packet (present only with MUX_RR_PKT_EN)
- out_data  output  WIDTH  registered output beat
- out_valid  output  1  out_data holds a beat
- out_ready  input  1  consumer accepts beat
- out_sel  output  SEL_W  channel index that out_data came from
- out_last  output  1  registered copy of in_last (present only with MUX_RR_PKT_EN)

Clocking is fixed: one clock, clk; reset is rst_n, asynchronous, active-low.

## Operation
- Transfer on a port occurs when valid and ready are both high at a rising edge.
- load = ~out_valid | out_ready (output register free or draining this cycle).
- Arbiter: combinational one-hot grant. Search starts at index ptr+1 mod CHANNELS and proceeds upward with wrap; the first channel with in_valid high wins.
- in_ready[i] = grant[i] & load. At most one in_ready bit is high in any cycle.
- On a transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g.
- If load and no in_valid bit is set: out_valid <= 0; out_data and out_sel hold their values.
- While out_valid & ~out_ready: out_data, out_sel and out_valid are held stable, and all in_ready bits are 0.
- ptr changes only on input transfers. An idle channel loses no priority.
- Inputs are not required to hold in_valid. The grant is recomputed every cycle from the current in_valid.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=CHANNELS-1, so channel 0 has first priority after reset.
- An rst_n assertion mid-operation clears all state immediately, without waiting for a clock edge. Any beat in the output register is discarded.
- Latency: 1 cycle from an input transfer to out_valid.
- Throughput: 1 beat per cycle sustained when out_ready is held high.
- All channels valid continuously with out_ready=1: grants follow 0,1,2,…,CHANNELS-1,0,… with one beat per cycle.
- A single active channel is served every cycle, back-to-back.
- Wrap: with ptr=CHANNELS-1, the search order is 0..CHANNELS-1. With CHANNELS non-power-of-two, indices ≥CHANNELS never appear on out_sel.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on in_valid, out_valid and out_ready.

## Configuration
- MUX_RR_PKT_EN defined:
  - in_last and out_last ports exist.
  - Once channel g transfers a beat with in_last[g]=0, the grant is locked to g until the beat with in_last[g]=1 transfers.
  - While locked, other channels stay unready even if g deasserts in_valid.
  - ptr updates only on the last beat.
  - out_last is registered alongside out_data.
  - Reset clears the lock.
- MUX_RR_PKT_EN undefined:
  - in_last and out_last ports are absent.
  - Arbitration happens per beat as described in Operation.

## Test plan
- Reset check: hold rst_n=0, then release. Required: out_valid=0, out_data=0, out_sel=0. Then drive in_valid=4'b1111 with in_data={8'h33,8'h22,8'h11,8'h00} and out_ready=1. Required: out_sel sequence 0,1,2,3,0, out_data 00,11,22,33,00, one per cycle starting 1 cycle after the first transfer.
- Backpressure: channel 2 valid with data 8'hA5, out_ready=0 for 5 cycles. Required: out_valid=1, out_data=A5 and out_sel=2 held stable, all in_ready=0. Release out_ready. Required: exactly one A5 beat is delivered.
- Fairness with gaps: channels 1 and 3 valid, out_ready=1. Required: alternating 1,3,1,3. Drop channel 3 for 2 cycles. Required: channel 1 is served back-to-back. Re-assert channel 3. Required: channel 3 wins the next cycle.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1. Required: out_valid=0 immediately. After release, channel 0 has priority.
- CHANNELS=3, WIDTH=16: all channels valid. Required: out_sel sequence 0,1,2,0,1,2 and out_sel never equals 3.
- MUX_RR_PKT_EN defined: channel 0 sends a 3-beat packet with in_last on beat 3, and channel 1 is valid throughout. Required: output 0,0,0,1 with out_last=1 on the third beat. Channel 1 stays unready while channel 0 is mid-packet, including during a 1-cycle in_valid gap on channel 0.

Source files
------------

// File: rtl/mux_rr.sv
// N-channel round-robin multiplexer: valid/ready inputs merged onto one registered output.
// Define MUX_RR_PKT_EN to add in_last/out_last and hold the grant for a whole packet.
module mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef MUX_RR_PKT_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  // Handshake: a beat moves on any port when valid and ready are both high at a
  // rising clk edge. in_ready is combinational and never depends on in_ready.
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    gsel;
  logic [SEL_W-1:0]    idx;
  logic [CHANNELS-1:0] grant;
  logic                found;
  logic                load;

`ifdef MUX_RR_PKT_EN
  logic                locked;
  logic [SEL_W-1:0]    lock_ch;
`endif

  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {CHANNELS{load}};

  // Search starts one past the last granted channel and wraps at CHANNELS.
  always_comb begin
    grant = '0;
    gsel  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        gsel       = idx;
        found      = 1'b1;
      end
    end
`ifdef MUX_RR_PKT_EN
    if (locked) begin
      grant          = '0;
      gsel           = lock_ch;
      found          = in_valid[lock_ch];
      grant[lock_ch] = in_valid[lock_ch];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
`ifdef MUX_RR_PKT_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (load) begin
      if (found) begin
        out_data  <= in_data[int'(gsel)*WIDTH +: WIDTH];
        out_sel   <= gsel;
        out_valid <= 1'b1;
`ifdef MUX_RR_PKT_EN
        out_last  <= in_last[gsel];
        // Priority only advances once the packet is complete.
        if (in_last[gsel]) begin
          locked <= 1'b0;
          ptr    <= gsel;
        end else begin
          locked  <= 1'b1;
          lock_ch <= gsel;
        end
`else
        ptr       <= gsel;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
